// File: rtl/bnn_pe_feeder_if.sv
// bnn_pe_feeder_if: job request, operand stream, PE drive and result port of the BNN PE feeder.
interface bnn_pe_feeder_if #(
  parameter int WORD_SIZE = 64,
  parameter int LEN_W = 16
);
  logic start;
  logic [LEN_W-1:0] vec_len;
  logic [15:0] threshold;
  logic busy;
  logic in_valid;
  logic in_ready;
  logic [WORD_SIZE-1:0] in_weight;
  logic [WORD_SIZE-1:0] in_act;
  logic pe_ce;
  logic pe_accumulate;
  logic pe_test_mode;
  logic [WORD_SIZE-1:0] pe_weight;
  logic [WORD_SIZE-1:0] pe_act;
  logic [WORD_SIZE-1:0] pe_mask;
  logic [15:0] pe_sum;
  logic res_valid;
  logic res_ready;
  logic [15:0] res_sum;
  logic res_bit;
  modport master (
    input start, vec_len, threshold, in_valid, in_weight, in_act, pe_sum, res_ready,
    output busy, in_ready, pe_ce, pe_accumulate, pe_test_mode, pe_weight, pe_act, pe_mask,
    output res_valid, res_sum, res_bit
  );
  modport slave (
    output start, vec_len, threshold, in_valid, in_weight, in_act, pe_sum, res_ready,
    input busy, in_ready, pe_ce, pe_accumulate, pe_test_mode, pe_weight, pe_act, pe_mask,
    input res_valid, res_sum, res_bit
  );
endinterface

// File: rtl/bnn_pe_feeder.sv
// bnn_pe_feeder: sequences one XNOR-popcount dot-product job through a BNN PE and returns the binarized sum.
module bnn_pe_feeder #(
  parameter int WORD_SIZE = 64,
  parameter int LEN_W = 16
) (
  input logic clk,
  input logic reset,
  bnn_pe_feeder_if.master bus
);
  localparam int LB = $clog2(WORD_SIZE);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, STREAM = 3'd2, DRAIN = 3'd3, CAPT = 3'd4, RESULT = 3'd5;
  logic [2:0] state_q, state_d;
  logic [LEN_W-1:0] nwords_q, nwords_d, k_q, k_d;
  logic [LB-1:0] rem_q, rem_d;
  logic [15:0] thr_q, thr_d, res_sum_q, res_sum_d;
  logic busy_q, busy_d, in_ready_q, in_ready_d, pe_ce_q, pe_ce_d, pe_acc_q, pe_acc_d;
  logic res_valid_q, res_valid_d, res_bit_q, res_bit_d;
  logic [WORD_SIZE-1:0] pe_weight_q, pe_weight_d, pe_act_q, pe_act_d, pe_mask_q, pe_mask_d;
  logic start_ok, len_zero, hs, last_k;
  always_comb begin
    start_ok = state_q == IDLE && bus.start;
    len_zero = bus.vec_len == '0;
    hs = state_q == STREAM && bus.in_valid && in_ready_q;
    last_k = k_q == nwords_q - LEN_W'(1);
    case (state_q)
      IDLE:    state_d = start_ok ? (len_zero ? RESULT : CLEAR) : IDLE;
      CLEAR:   state_d = STREAM;
      STREAM:  state_d = hs && last_k ? DRAIN : STREAM;
      DRAIN:   state_d = CAPT;
      CAPT:    state_d = RESULT;
      RESULT:  state_d = bus.res_ready ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
    nwords_d = start_ok ? (bus.vec_len >> LB) + LEN_W'(|bus.vec_len[LB-1:0]) : nwords_q;
    rem_d = start_ok ? bus.vec_len[LB-1:0] : rem_q;
    thr_d = start_ok ? bus.threshold : thr_q;
    k_d = start_ok ? '0 : hs ? k_q + LEN_W'(1) : k_q;
    busy_d = state_d != IDLE;
    in_ready_d = state_d == STREAM;
    pe_ce_d = state_d == CLEAR || hs;
    pe_acc_d = hs;
    pe_weight_d = hs ? bus.in_weight : pe_weight_q;
    pe_act_d = hs ? bus.in_act : pe_act_q;
    // only the final word of a job with a partial tail gets a narrowed mask
    pe_mask_d = !hs ? '0 : (!last_k || rem_q == '0) ? '1 : ~({WORD_SIZE{1'b1}} << rem_q);
    res_valid_d = state_d == RESULT;
    res_sum_d = state_q == CAPT ? bus.pe_sum : (start_ok && len_zero) ? '0 : res_sum_q;
    res_bit_d = state_q == CAPT ? bus.pe_sum >= thr_q : (start_ok && len_zero) ? bus.threshold == '0 : res_bit_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      nwords_q <= '0;
      k_q <= '0;
      rem_q <= '0;
      thr_q <= '0;
      busy_q <= 1'b0;
      in_ready_q <= 1'b0;
      pe_ce_q <= 1'b0;
      pe_acc_q <= 1'b0;
      pe_weight_q <= '0;
      pe_act_q <= '0;
      pe_mask_q <= '0;
      res_valid_q <= 1'b0;
      res_sum_q <= '0;
      res_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nwords_q <= nwords_d;
      k_q <= k_d;
      rem_q <= rem_d;
      thr_q <= thr_d;
      busy_q <= busy_d;
      in_ready_q <= in_ready_d;
      pe_ce_q <= pe_ce_d;
      pe_acc_q <= pe_acc_d;
      pe_weight_q <= pe_weight_d;
      pe_act_q <= pe_act_d;
      pe_mask_q <= pe_mask_d;
      res_valid_q <= res_valid_d;
      res_sum_q <= res_sum_d;
      res_bit_q <= res_bit_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.in_ready = in_ready_q;
  assign bus.pe_ce = pe_ce_q;
  assign bus.pe_accumulate = pe_acc_q;
  assign bus.pe_test_mode = 1'b0;
  assign bus.pe_weight = pe_weight_q;
  assign bus.pe_act = pe_act_q;
  assign bus.pe_mask = pe_mask_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_sum = res_sum_q;
  assign bus.res_bit = res_bit_q;
endmodule

// File: tb/tb_bnn_pe_feeder.sv
// tb_bnn_pe_feeder: drives random and directed jobs through the feeder plus a PE model, checking against a bit-level reference.
module tb_bnn_pe_feeder;
  localparam int W = 64;
  localparam int LW = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int clr_cnt = 0;
  logic [W-1:0] wq[$], aq[$], mq[$];
  always #5 clk = ~clk;
  bnn_pe_feeder_if #(.WORD_SIZE(W), .LEN_W(LW)) bus ();
  bnn_pe_feeder #(.WORD_SIZE(W), .LEN_W(LW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge reset)
    if (reset) bus.pe_sum <= '0;
    else if (bus.pe_ce)
      bus.pe_sum <= bus.pe_accumulate ? bus.pe_sum + 16'($countones(~(bus.pe_weight ^ bus.pe_act) & bus.pe_mask)) : '0;
  always @(negedge clk)
    if (!reset && bus.pe_ce) begin
      if (bus.pe_accumulate) mq.push_back(bus.pe_mask);
      else clr_cnt++;
    end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic fill(input int len, input int mode);
    int nw;
    logic [W-1:0] w;
    nw = (len + W - 1) / W;
    wq.delete();
    aq.delete();
    for (int k = 0; k < nw; k++) begin
      w = {$urandom, $urandom};
      case (mode)
        0: begin wq.push_back(w); aq.push_back({$urandom, $urandom}); end
        1: begin wq.push_back(w); aq.push_back(w); end
        2: begin wq.push_back('1); aq.push_back('1); end
        default: begin wq.push_back(w); aq.push_back(k == 1 ? ~w : w); end
      endcase
    end
  endtask
  function automatic int ref_sum(input int len);
    int s;
    logic [W-1:0] ww, aa;
    s = 0;
    for (int i = 0; i < len; i++) begin
      ww = wq[i / W];
      aa = aq[i / W];
      s += (ww[i % W] == aa[i % W]) ? 1 : 0;
    end
    return s;
  endfunction
  function automatic logic [W-1:0] ref_mask(input int len, input int k);
    logic [W-1:0] m;
    for (int b = 0; b < W; b++) m[b] = (k * W + b < len);
    return m;
  endfunction
  task automatic run_job(input int len, input int thr, input int gap, input int stall);
    int nw, idx, wt, last_hs, g, es;
    logic eb;
    nw = (len + W - 1) / W;
    es = ref_sum(len);
    eb = es >= thr;
    mq.delete();
    clr_cnt = 0;
    idx = 0;
    wt = 0;
    last_hs = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.vec_len = LW'(len);
    bus.threshold = 16'(thr);
    @(negedge clk);
    bus.start = 1'b0;
    bus.vec_len = LW'($urandom);
    bus.threshold = 16'($urandom);
    if (len == 0) chk("len0_valid", bus.res_valid, 1);
    else chk("busy", bus.busy, 1);
    g = 0;
    while (idx < nw && g < 20000) begin
      if (wt > 0) begin
        bus.in_valid = 1'b0;
        wt--;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_weight = wq[idx];
        bus.in_act = aq[idx];
      end
      if (bus.in_valid && bus.in_ready) begin
        idx++;
        last_hs = cyc;
        wt = gap < 0 ? int'($urandom_range(0, 2)) : gap;
      end
      @(negedge clk);
      g++;
    end
    bus.in_valid = 1'b0;
    bus.in_weight = {$urandom, $urandom};
    chk("fed", idx, nw);
    g = 0;
    while (!bus.res_valid && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("res_valid", bus.res_valid, 1);
    if (len > 0) chk("latency", cyc - last_hs, 3);
    chk("sum", bus.res_sum, es);
    chk("bit", bus.res_bit, eb);
    chk("beats", mq.size(), nw);
    chk("clears", clr_cnt, len > 0);
    for (int k = 0; k < mq.size(); k++) chk($sformatf("mask%0d", k), mq[k], ref_mask(len, k));
    for (int s = 0; s < stall; s++) begin
      bus.res_ready = 1'b0;
      bus.start = s[0] == 1'b0;
      bus.vec_len = LW'($urandom_range(1, 500));
      @(negedge clk);
      bus.start = 1'b0;
      chk("hold_sum", bus.res_sum, es);
      chk("hold_bit", bus.res_bit, eb);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_ready", bus.in_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("valid_drop", bus.res_valid, 0);
    chk("idle", bus.busy, 0);
    @(negedge clk);
    chk("no_queue", bus.busy, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int len, g;
    bus.start = 1'b0;
    bus.vec_len = '0;
    bus.threshold = '0;
    bus.in_valid = 1'b0;
    bus.in_weight = '0;
    bus.in_act = '0;
    bus.res_ready = 1'b0;
    #1;
    chk("rst_ctl", {bus.busy, bus.in_ready, bus.pe_ce, bus.pe_accumulate, bus.res_valid, bus.res_bit}, 0);
    chk("rst_mask", bus.pe_mask, 0);
    chk("rst_sum", bus.res_sum, 0);
    chk("test_mode", bus.pe_test_mode, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fill(64, 2);
    run_job(64, 32, 0, 0);
    fill(100, 1);
    run_job(100, 60, 0, 0);
    chk("mask100", mq[1], 64'h0000000FFFFFFFFF);
    fill(192, 3);
    run_job(192, 100, 2, 0);
    chk("sum192", bus.res_sum, 128);
    fill(0, 0);
    run_job(0, 0, 0, 0);
    chk("len0_bit", bus.res_bit, 1);
    fill(130, 1);
    run_job(130, 200, -1, 5);
    // abandon a job after its first beat
    fill(192, 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.vec_len = 16'd192;
    bus.threshold = 16'd10;
    @(negedge clk);
    bus.start = 1'b0;
    g = 0;
    while (g < 10) begin
      bus.in_valid = 1'b1;
      bus.in_weight = wq[0];
      bus.in_act = aq[0];
      if (bus.in_ready) g = 100;
      @(negedge clk);
      g++;
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_ce", bus.pe_ce, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ctl", {bus.busy, bus.in_ready, bus.pe_ce, bus.pe_accumulate, bus.res_valid, bus.res_bit}, 0);
    chk("mid_rst_mask", bus.pe_mask, 0);
    chk("mid_rst_w", bus.pe_weight, 0);
    chk("mid_rst_a", bus.pe_act, 0);
    @(negedge clk);
    reset = 1'b0;
    fill(64, 1);
    run_job(64, 64, 0, 0);
    fill(1, 1);
    run_job(1, 1, 0, 0);
    fill(128, 0);
    run_job(128, 64, -1, 1);
    fill(65535, 2);
    run_job(65535, 65535, 0, 1);
    for (int j = 0; j < 20; j++) begin
      len = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 8)) : int'($urandom_range(1, 400));
      fill(len, int'($urandom_range(0, 1)));
      run_job(len, int'($urandom_range(0, len + 4)), -1, int'($urandom_range(0, 3)));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/bnn_pe_feeder.md
Name: bnn_pe_feeder

Overview:
Sequencer that drives one BNN XNOR-popcount PE for a single dot-product job.
- Accepts a job with a bit length and a threshold.
- Pulls weight/activation words from an upstream valid/ready stream.
- Issues the PE clear and accumulate beats, generating the tail mask for a partial last word.
- Captures the PE's registered 16-bit sum and returns it with a binarized output bit over a valid/ready result port.
- Sits between the layer scheduler's operand streams and the PE, on the PE's input side.

Parameters:
WORD_SIZE, 64, bits per operand word. Power of two, 8..64.
LEN_W, 16, width of vec_len. Legal range 7..16, so the maximum sum fits in pe_sum.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  job request pulse; honoured only in IDLE
vec_len  in  LEN_W  number of valid bits in the job; sampled on the accepted start
threshold  in  16  binarization threshold; sampled on the accepted start
busy  out  1  high in every state except IDLE
in_valid  in  1  operand word valid
in_ready  out  1  operand word ready
in_weight  in  WORD_SIZE  weight word; bit 0 is the first element
in_act  in  WORD_SIZE  activation word
pe_ce  out  1  PE clock enable
pe_accumulate  out  1  1 = accumulate, 0 = clear PE sum
pe_test_mode  out  1  tied to 0
pe_weight  out  WORD_SIZE  weight word presented to the PE
pe_act  out  WORD_SIZE  activation word presented to the PE
pe_mask  out  WORD_SIZE  valid-bit mask presented to the PE
pe_sum  in  16  PE accumulated sum (registered inside the PE)
res_valid  out  1  result valid
res_ready  in  1  result ready
res_sum  out  16  captured popcount sum
res_bit  out  1  binarized result: (res_sum >= threshold), unsigned compare

Behaviour:
- Register rules:
  - All outputs are registered.
  - Async reset forces state IDLE and every output to 0.
  - Reset mid-job abandons the job; no result is produced.
- Latched on an accepted start:
  - len = vec_len, thr = threshold.
  - nwords = ceil(len/WORD_SIZE); rem = len mod WORD_SIZE.
  - Word counter k is cleared.
- IDLE:
  - Outputs: busy=0, in_ready=0, pe_ce=0, pe_mask=0.
  - start with len==0: go to RESULT; res_sum=0, res_bit=(0>=thr); res_valid=1 in the next cycle.
  - start with len>0: go to CLEAR.
- CLEAR (1 cycle):
  - Outputs: pe_ce=1, pe_accumulate=0, pe_mask=0. The PE sum is zero after this edge.
  - Next state STREAM.
- STREAM:
  - Outputs: in_ready=1.
  - Handshake (in_valid & in_ready) in cycle t, next cycle t+1:
    - pe_ce=1, pe_accumulate=1.
    - pe_weight/pe_act = captured words.
    - pe_mask = all ones if k<nwords-1, or if rem==0; else low rem bits set.
    - k increments.
  - Cycle without a handshake: pe_ce=0 in the next cycle. pe_weight/pe_act hold; pe_mask=0.
  - Handshake of the last word (k==nwords-1): in_ready drops next cycle; go to DRAIN.
- DRAIN (1 cycle):
  - The last word is presented (pe_ce=1); in_ready=0.
  - Next state CAPT.
- CAPT (1 cycle):
  - pe_ce=0; pe_sum is now final.
  - res_sum<=pe_sum and res_bit<=(pe_sum>=thr) at the end of the cycle.
  - Next state RESULT.
- RESULT:
  - res_valid=1; res_sum and res_bit stay stable until res_ready.
  - On res_valid & res_ready: res_valid=0 next cycle; go to IDLE.
- Job timing:
  - Latency from the last operand handshake to res_valid = 3 cycles.
  - Minimum job duration is 1 + nwords + 3 cycles.
- start while busy is ignored and is not queued.
- Words beyond nwords are never accepted; in_ready=0 outside STREAM.
- The sum never wraps, since len ≤ 2^LEN_W−1 ≤ 65535.

Test Plan:
Bench connects the feeder to the BNN PE model. Clear/accumulate semantics: sum<=0, or sum+popcount(~(w^a)&mask), on edges with ce=1.
- len=64, thr=32, one beat w=a=all ones → one CLEAR cycle, one pe_ce beat with mask all ones; res_sum=64, res_bit=1, res_valid 3 cycles after the handshake.
- len=100, thr=60, two beats w=a → 2nd beat pe_mask=0x0000000FFFFFFFFF; res_sum=100, res_bit=1.
- len=192, w=~a on beat 1, w=a on beats 0 and 2, in_valid low for 2 cycles between beats → pe_ce only on beat cycles; res_sum=128.
- len=0, thr=0 → no pe_ce pulses; res_valid in the cycle after start; res_sum=0, res_bit=1.
- res_ready held 0 for 5 cycles in RESULT → res_sum/res_bit stable; start pulses ignored; in_ready=0; IDLE one cycle after res_ready=1.
- reset asserted during STREAM after 1 of 3 beats → all outputs 0 immediately; a new job with len=64, w=a yields res_sum=64.
